// File: rtl/seq_cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
//   state_t      : controller FSM states
//   cmp_result_t : registered lt/eq/gt result flags
//   nchunk()     : ceiling division of operand width by chunk width
package seq_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_result_t;

  function automatic int unsigned nchunk(int unsigned width, int unsigned chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/chunk_compare.sv
// Combinational unsigned magnitude compare of one CHUNK-bit slice.
//   a_i, b_i : slice operands
//   lt_o     : a_i < b_i
//   eq_o     : a_i == b_i
//   gt_o     : a_i > b_i
module chunk_compare #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic             lt_o,
  output logic             eq_o,
  output logic             gt_o
);

  assign lt_o = (a_i < b_i);
  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i > b_i);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator. Operands are compared MSB-first, CHUNK bits per
// clock, stopping at the first differing chunk. Signed mode is handled by flipping the
// sign bit at capture (offset binary), so the datapath is always an unsigned compare.
//   clk_i, rst_n_i      : clock, asynchronous active-low reset
//   start_i             : request, sampled only in IDLE
//   signed_i            : 1 = two's-complement compare
//   A_i, B_i            : operands, captured on accepted start
//   busy_o              : high in COMPARE and DONE
//   done_o              : one-cycle pulse when result flags become valid
//   A_*_B_o             : registered result flags, held until the next capture
module seq_magnitude_comparator
  import seq_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             A_less_than_B_o,
  output logic             A_equal_B_o,
  output logic             A_greater_than_B_o
);

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned PW     = NCHUNK * CHUNK;
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [PW-1:0]  a_q, a_d, b_q, b_d;
  logic           done_q, done_d;
  cmp_result_t    res_q, res_d;

  logic [CHUNK-1:0] a_slice, b_slice;
  logic             c_lt, c_eq, c_gt;
  logic [PW-1:0]    a_ext, b_ext;

  assign a_slice = a_q[int'(idx_q) * CHUNK +: CHUNK];
  assign b_slice = b_q[int'(idx_q) * CHUNK +: CHUNK];

  chunk_compare #(
    .CHUNK (CHUNK)
  ) u_chunk_compare (
    .a_i  (a_slice),
    .b_i  (b_slice),
    .lt_o (c_lt),
    .eq_o (c_eq),
    .gt_o (c_gt)
  );

  // Zero-extend into the padded width; padding is equal in both so it never decides.
  always_comb begin
    a_ext = '0;
    b_ext = '0;
    a_ext[WIDTH-1:0] = A_i;
    b_ext[WIDTH-1:0] = B_i;
    if (signed_i) begin
      a_ext[WIDTH-1] = ~A_i[WIDTH-1];
      b_ext[WIDTH-1] = ~B_i[WIDTH-1];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_ext;
          b_d     = b_ext;
          idx_d   = IW'(NCHUNK - 1);
          res_d   = '0;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (!c_eq) begin
          res_d   = '{lt: c_lt, eq: 1'b0, gt: c_gt};
          done_d  = 1'b1;
          state_d = DONE;
        end else if (idx_q == '0) begin
          res_d   = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign busy_o             = (state_q != IDLE);
  assign done_o             = done_q;
  assign A_less_than_B_o    = res_q.lt;
  assign A_equal_B_o        = res_q.eq;
  assign A_greater_than_B_o = res_q.gt;

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Parametrised, multi-cycle successor to the 17-bit combinational comparator used by the square-root datapath. It compares two WIDTH-bit operands MSB-first, CHUNK bits per clock, and terminates early at the first differing chunk. It supports unsigned and two's-complement modes and returns less, equal and greater flags through a start/done handshake. It sits beside the square-root controller, which issues one comparison at a time.

Parameters:
WIDTH, 17, operand width in bits (>=2)
CHUNK, 4, bits examined per cycle (1..WIDTH); NCHUNK = ceil(WIDTH/CHUNK)

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  request; sampled only in IDLE
signed_i  in  1  1 = two's-complement compare, 0 = unsigned; captured with operands
A_i  in  WIDTH  operand A; captured on accepted start
B_i  in  WIDTH  operand B; captured on accepted start
busy_o  out  1  high in COMPARE and DONE
done_o  out  1  one-cycle pulse; result valid
A_less_than_B_o  out  1  registered result
A_equal_B_o  out  1  registered result
A_greater_than_B_o  out  1  registered result

Behaviour:
- Single clock (clk_i). Reset is asynchronous and active-low (rst_n_i): state=IDLE, chunk index=0, operand regs=0, busy_o=0, done_o=0, all three result flags=0.
- FSM states: IDLE, COMPARE, DONE.
- IDLE: on an edge with start_i=1, operands are captured. Each operand is zero-extended to NCHUNK*CHUNK bits. If signed_i=1, bit WIDTH-1 of both operands is inverted before storage (offset-binary), so a single unsigned compare covers both modes. Index is set to NCHUNK-1 and state goes to COMPARE. start_i=0 keeps IDLE.
- COMPARE: each edge compares chunk[index] of A and B combinationally.
  - Chunks differ: set lt/gt accordingly, eq=0, assert done_o, go to DONE.
  - Chunks equal and index=0: eq=1, lt=gt=0, assert done_o, go to DONE.
  - Otherwise decrement index and stay in COMPARE.
- DONE: done_o deasserts on the next edge and state returns to IDLE. Result flags hold until the next accepted start; they are cleared to 0 at the capture edge.
- Latency: capture edge E0. Let k be the number of chunks examined (1..NCHUNK). done_o is high for exactly the cycle following edge Ek. Equal operands take k=NCHUNK. The earliest new start is accepted at edge Ek+2.
- Exactly one of lt/eq/gt is 1 while done_o=1 and thereafter until the next capture.
- start_i while busy_o=1 (COMPARE or DONE) is ignored; there is no queueing and in-flight operands are unaffected.
- Input changes on A_i/B_i/signed_i after capture have no effect.
- Reset asserted mid-operation aborts immediately with all outputs at reset values. No done_o pulse follows reset release.
- Partial top chunk: padding bits are 0 in both operands and never decide the result.

Decomposition:
- Package seq_cmp_pkg holds:
  - typedef enum state_t {IDLE, COMPARE, DONE};
  - function nchunk(WIDTH, CHUNK) returning the ceiling division;
  - packed struct cmp_result_t {lt, eq, gt}.
- Sub-module chunk_compare (parameter CHUNK): combinational, inputs a_i/b_i [CHUNK], outputs lt_o/eq_o/gt_o. It is instantiated once and fed by an index-selected slice.

Test Plan:
- WIDTH=17, CHUNK=4 (NCHUNK=5), unsigned, A=1FFFF, B=1FFFE -> gt=1, lt=eq=0; differ at chunk 0, k=5, done_o high in the cycle after E5.
- Same config, signed_i=1, A=10000 (-65536), B=00001 -> lt=1, k=1. Repeat with signed_i=0 -> gt=1, k=1.
- A=B=0ABCD, unsigned -> eq=1, k=5. Same operands with signed_i=1 -> eq=1.
- Start accepted with A=00000, B=1FFFF (unsigned, lt=1). Drive start_i=1 continuously with A=1FFFF, B=00000:
  - first result lt=1, k=1;
  - second start accepted at E3;
  - second result gt=1.
- Start A=0F000, B=0F001, then drop rst_n_i at the cycle after E2:
  - all outputs 0 immediately;
  - after release, no done_o while start_i=0.
- WIDTH=8, CHUNK=3 (NCHUNK=3, one pad bit), signed, A=80 (-128), B=7F -> lt=1, k=1.
- Random sweep of 1000 operand pairs per mode against a golden $signed/$unsigned compare; latency is checked against k each time.
